// File: rtl/age_queue_entry_allocator.sv
// age_queue_entry_allocator
//   Hands out free entry tags of an age-ordered queue and takes them back.
//   Tracks a free mask plus a registered free count, and forwards grants and
//   releases to the age-order selector as same-cycle enqueue/dequeue strobes.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   alloc_vld_i     per-slot allocation request            [ENQ_WIDTH]
//   alloc_rdy_o     per-slot ready (a free entry exists)    [ENQ_WIDTH]
//   alloc_tag_o     tag offered to each slot                [ENQ_WIDTH][ENTRY_TAG]
//   enq_vld_o/tag_o enqueue strobe/tag to selector          [ENQ_WIDTH]
//   rel_vld_i/tag_i release request/tag                     [DEQ_WIDTH]
//   deq_vld_o/tag_o dequeue strobe/tag to selector          [DEQ_WIDTH]
//   flush_i         free every entry, suppress grants/releases this cycle
//   free_cnt_o      registered free-entry count
//   full_o/empty_o  no free entry / every entry free
//   err_o           sticky protocol error (double release), cleared by rst only
module age_queue_entry_allocator #(
  parameter  int ENTRY_COUNT = 4,
  parameter  int ENQ_WIDTH   = 1,
  parameter  int DEQ_WIDTH   = 1,
  localparam int ENTRY_TAG   = $clog2(ENTRY_COUNT),
  localparam int CNT_W       = $clog2(ENTRY_COUNT + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ENQ_WIDTH-1:0]                alloc_vld_i,
  output logic [ENQ_WIDTH-1:0]                alloc_rdy_o,
  output logic [ENQ_WIDTH-1:0][ENTRY_TAG-1:0] alloc_tag_o,
  output logic [ENQ_WIDTH-1:0]                enq_vld_o,
  output logic [ENQ_WIDTH-1:0][ENTRY_TAG-1:0] enq_tag_o,
  input  logic [DEQ_WIDTH-1:0]                rel_vld_i,
  input  logic [DEQ_WIDTH-1:0][ENTRY_TAG-1:0] rel_tag_i,
  output logic [DEQ_WIDTH-1:0]                deq_vld_o,
  output logic [DEQ_WIDTH-1:0][ENTRY_TAG-1:0] deq_tag_o,
  input  logic                                flush_i,
  output logic [CNT_W-1:0]                    free_cnt_o,
  output logic                                full_o,
  output logic                                empty_o,
  output logic                                err_o
);

  logic [ENTRY_COUNT-1:0] free_q, free_d;
  logic [CNT_W-1:0]       free_cnt_q, free_cnt_d;
  logic                   err_q, err_d;

  // Slot i is offered the (i+1)-th lowest free index. Offsets do not depend
  // on which slots actually request, so a gap in alloc_vld_i just leaves
  // that tag unused this cycle.
  always_comb begin
    int rank;
    alloc_tag_o = '0;
    rank        = 0;
    for (int j = 0; j < ENTRY_COUNT; j++) begin
      if (free_q[j]) begin
        for (int i = 0; i < ENQ_WIDTH; i++)
          if (rank == i) alloc_tag_o[i] = ENTRY_TAG'(j);
        rank++;
      end
    end
  end

  for (genvar i = 0; i < ENQ_WIDTH; i++) begin : g_slot
    assign alloc_rdy_o[i] = (free_cnt_q > CNT_W'(i)) & ~flush_i;
  end

  assign enq_vld_o = alloc_vld_i & alloc_rdy_o;
  assign enq_tag_o = alloc_tag_o;
  assign deq_vld_o = rel_vld_i & {DEQ_WIDTH{~flush_i}};
  assign deq_tag_o = rel_tag_i;

  // Grants clear bits, releases set them. A release can only target an entry
  // that was allocated (else it is an error), so the two never collide in a
  // legal cycle; a released entry becomes offerable only from the next cycle.
  // The count is the popcount of the next mask, so a double release cannot
  // inflate it.
  always_comb begin
    free_d = free_q;
    err_d  = err_q;
    if (flush_i) begin
      free_d = '1;
    end else begin
      for (int i = 0; i < ENQ_WIDTH; i++)
        if (enq_vld_o[i]) free_d[alloc_tag_o[i]] = 1'b0;
      for (int j = 0; j < DEQ_WIDTH; j++) begin
        if (deq_vld_o[j]) begin
          if (int'(rel_tag_i[j]) < ENTRY_COUNT) begin
            if (free_q[rel_tag_i[j]]) err_d = 1'b1;
            free_d[rel_tag_i[j]] = 1'b1;
          end
          for (int k = j + 1; k < DEQ_WIDTH; k++)
            if (deq_vld_o[k] && (rel_tag_i[k] == rel_tag_i[j])) err_d = 1'b1;
        end
      end
    end
    free_cnt_d = '0;
    for (int j = 0; j < ENTRY_COUNT; j++)
      free_cnt_d = free_cnt_d + CNT_W'(free_d[j]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_q     <= '1;
      free_cnt_q <= CNT_W'(ENTRY_COUNT);
      err_q      <= 1'b0;
    end else begin
      free_q     <= free_d;
      free_cnt_q <= free_cnt_d;
      err_q      <= err_d;
    end
  end

  assign free_cnt_o = free_cnt_q;
  assign full_o     = (free_cnt_q == '0);
  assign empty_o    = (free_cnt_q == CNT_W'(ENTRY_COUNT));
  assign err_o      = err_q;

endmodule

// File: tb/tb_age_queue_entry_allocator.sv
// Directed bench for age_queue_entry_allocator: a 1-slot instance (u_dut1)
// and a 2-slot/2-release instance (u_dut2), plus a short random traffic run
// on u_dut1 against a free-mask model.
module tb_age_queue_entry_allocator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---- 1-slot instance ----
  logic [0:0]      a_vld1, a_rdy1, e_vld1, r_vld1, d_vld1;
  logic [0:0][1:0] a_tag1, e_tag1, r_tag1, d_tag1;
  logic            fl1, full1, empty1, err1;
  logic [2:0]      cnt1;

  age_queue_entry_allocator #(.ENTRY_COUNT(4), .ENQ_WIDTH(1), .DEQ_WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .alloc_vld_i(a_vld1), .alloc_rdy_o(a_rdy1), .alloc_tag_o(a_tag1),
    .enq_vld_o(e_vld1), .enq_tag_o(e_tag1),
    .rel_vld_i(r_vld1), .rel_tag_i(r_tag1),
    .deq_vld_o(d_vld1), .deq_tag_o(d_tag1),
    .flush_i(fl1), .free_cnt_o(cnt1), .full_o(full1), .empty_o(empty1), .err_o(err1)
  );

  // ---- 2-slot instance ----
  logic [1:0]      a_vld2, a_rdy2, e_vld2, r_vld2, d_vld2;
  logic [1:0][1:0] a_tag2, e_tag2, r_tag2, d_tag2;
  logic            fl2, full2, empty2, err2;
  logic [2:0]      cnt2;

  age_queue_entry_allocator #(.ENTRY_COUNT(4), .ENQ_WIDTH(2), .DEQ_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .alloc_vld_i(a_vld2), .alloc_rdy_o(a_rdy2), .alloc_tag_o(a_tag2),
    .enq_vld_o(e_vld2), .enq_tag_o(e_tag2),
    .rel_vld_i(r_vld2), .rel_tag_i(r_tag2),
    .deq_vld_o(d_vld2), .deq_tag_o(d_tag2),
    .flush_i(fl2), .free_cnt_o(cnt2), .full_o(full2), .empty_o(empty2), .err_o(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1, outputs are sampled at the negedge.
  task automatic nxt;
    @(posedge clk); #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask

  function automatic int lowest_free(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int popc(input logic [3:0] m);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(m[i]);
    return c;
  endfunction

  initial begin
    logic [3:0] mfree;
    int         rt;
    logic       av, rv;

    rst = 1'b1;
    a_vld1 = '0; r_vld1 = '0; r_tag1 = '0; fl1 = 1'b0;
    a_vld2 = '0; r_vld2 = '0; r_tag2 = '0; fl2 = 1'b0;
    nxt(); nxt();
    rst = 1'b0;

    // ---------------- reset state ----------------
    smp();
    chk("rst_cnt",   cnt1,   4);
    chk("rst_empty", empty1, 1);
    chk("rst_full",  full1,  0);
    chk("rst_err",   err1,   0);
    chk("rst_rdy",   a_rdy1, 1);
    chk("rst_rdy2",  a_rdy2, 2'b11);

    // ---------------- fill one entry per cycle ----------------
    nxt();
    a_vld1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      smp();
      chk("fill_enq_vld", e_vld1, 1);
      chk("fill_enq_tag", e_tag1, c);
      chk("fill_cnt",     cnt1,   4 - c);
      nxt();
    end
    smp();
    chk("full_cnt",  cnt1,   0);
    chk("full_full", full1,  1);
    chk("full_rdy",  a_rdy1, 0);
    chk("full_enq",  e_vld1, 0);

    // ---------------- release 2 while full and requesting ----------------
    nxt();
    r_vld1 = 1'b1; r_tag1 = 2'd2;
    smp();
    chk("relfull_enq", e_vld1, 0);
    chk("relfull_deq", d_vld1, 1);
    chk("relfull_deq_tag", d_tag1, 2);
    nxt();
    r_vld1 = 1'b0;
    smp();
    chk("relfull_tag", a_tag1, 2);
    chk("relfull_rdy", a_rdy1, 1);
    chk("relfull_cnt", cnt1,   1);
    nxt();                         // tag 2 taken again -> full
    a_vld1 = 1'b0;
    smp();
    chk("refull_cnt", cnt1, 0);

    // ---------------- double release -> sticky error ----------------
    nxt();
    r_vld1 = 1'b1; r_tag1 = 2'd0;  // legal release
    nxt();                         // releasing 0 again is illegal
    smp();
    chk("rel0_cnt", cnt1, 1);
    chk("rel0_err", err1, 0);
    nxt();
    r_vld1 = 1'b0;
    smp();
    chk("dbl_err", err1, 1);
    chk("dbl_cnt", cnt1, 1);

    // flush holds the error, frees all, suppresses the release
    nxt();
    fl1 = 1'b1; r_vld1 = 1'b1; r_tag1 = 2'd1;
    smp();
    chk("fl_deq", d_vld1, 0);
    nxt();
    fl1 = 1'b0; r_vld1 = 1'b0;
    smp();
    chk("fl_cnt",   cnt1,   4);
    chk("fl_empty", empty1, 1);
    chk("fl_err",   err1,   1);

    // ---------------- alloc 0,1 then alloc+release same cycle ----------------
    nxt();
    a_vld1 = 1'b1;
    nxt(); nxt();
    r_vld1 = 1'b1; r_tag1 = 2'd0;
    smp();
    chk("ar_cnt",     cnt1,   2);
    chk("ar_enq_vld", e_vld1, 1);
    chk("ar_enq_tag", e_tag1, 2);
    chk("ar_deq_vld", d_vld1, 1);
    nxt();                         // free = {0,3}
    r_tag1 = 2'd1;
    fl1 = 1'b1;
    smp();
    chk("ar2_cnt",  cnt1,   2);
    chk("ar2_tag",  a_tag1, 0);
    chk("flx_enq",  e_vld1, 0);
    chk("flx_deq",  d_vld1, 0);
    chk("flx_rdy",  a_rdy1, 0);
    nxt();
    fl1 = 1'b0; r_vld1 = 1'b0;
    smp();
    chk("flx_cnt",   cnt1,   4);
    chk("flx_empty", empty1, 1);
    chk("flx_err",   err1,   1);

    // ---------------- reset beats allocation, clears error ----------------
    nxt();
    rst = 1'b1;                    // a_vld1 still 1
    nxt();
    rst = 1'b0; a_vld1 = 1'b0;
    smp();
    chk("rst2_cnt", cnt1, 4);
    chk("rst2_err", err1, 0);

    // ---------------- 2-slot instance ----------------
    nxt();
    a_vld2 = 2'b11;
    smp();
    chk("d2_enq_vld0", e_vld2, 2'b11);
    chk("d2_enq_tag0", e_tag2, {2'd1, 2'd0});
    nxt();
    smp();
    chk("d2_cnt1",     cnt2,   2);
    chk("d2_enq_tag1", e_tag2, {2'd3, 2'd2});
    nxt();
    a_vld2 = 2'b00;
    r_vld2 = 2'b11; r_tag2 = {2'd3, 2'd1};
    nxt();
    r_vld2 = 2'b00;
    smp();
    chk("d2_cnt_rel", cnt2, 2);
    nxt();
    a_vld2 = 2'b11;
    smp();
    chk("d2_enq_vld13", e_vld2, 2'b11);
    chk("d2_enq_tag13", e_tag2, {2'd3, 2'd1});
    nxt();
    a_vld2 = 2'b00;
    smp();
    chk("d2_cnt0",  cnt2,  0);
    chk("d2_full",  full2, 1);
    nxt();
    r_vld2 = 2'b11; r_tag2 = {2'd3, 2'd1};
    nxt();
    r_vld2 = 2'b00;
    a_vld2 = 2'b10;                // gap in slot 0
    smp();
    chk("d2_gap_rdy", a_rdy2, 2'b11);
    chk("d2_gap_vld", e_vld2, 2'b10);
    chk("d2_gap_tag", e_tag2[1], 3);
    nxt();
    a_vld2 = 2'b00;
    smp();
    chk("d2_gap_cnt", cnt2,      1);
    chk("d2_gap_t0",  a_tag2[0], 1);
    chk("d2_gap_r",   a_rdy2,    2'b01);
    nxt();
    r_vld2 = 2'b11; r_tag2 = {2'd0, 2'd0};   // both ports name tag 0
    nxt();
    r_vld2 = 2'b00;
    smp();
    chk("d2_dup_err", err2, 1);
    chk("d2_dup_cnt", cnt2, 2);
    chk("d2_err_other", err1, 0);

    // ---------------- random traffic on u_dut1 ----------------
    nxt();
    mfree = 4'b1111;
    for (int n = 0; n < 60; n++) begin
      av = 1'($urandom_range(0, 1));
      rv = 1'b0; rt = 0;
      if (mfree != 4'b1111 && $urandom_range(0, 1) == 1) begin
        rv = 1'b1;
        rt = $urandom_range(0, 3);
        for (int s = 0; s < 4 && mfree[rt]; s++) rt = (rt + 1) % 4;
      end
      a_vld1 = av; r_vld1 = rv; r_tag1 = 2'(rt);
      smp();
      chk("rnd_cnt", cnt1, popc(mfree));
      chk("rnd_enq", e_vld1, {31'd0, av && (mfree != 4'b0000)});
      if (av && mfree != 4'b0000) begin
        chk("rnd_tag", e_tag1, lowest_free(mfree));
        mfree[lowest_free(mfree)] = 1'b0;
      end
      if (rv) mfree[rt] = 1'b1;
      nxt();
    end
    a_vld1 = '0; r_vld1 = '0;
    smp();
    chk("rnd_final_cnt", cnt1, popc(mfree));
    chk("rnd_err", err1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/age_queue_entry_allocator.md
AGE_QUEUE_ENTRY_ALLOCATOR -- requirements
Module: age_queue_entry_allocator

Interface
REQ-001 Parameters SHALL be: ENTRY_COUNT, default 4, number of queue entries; ENQ_WIDTH, default 1, allocation ports; DEQ_WIDTH, default 1, release ports; ENTRY_TAG (localparam), $clog2(ENTRY_COUNT), tag width.
REQ-002 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst; ports are listed below, clock and reset first.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 alloc_vld_i  input  ENQ_WIDTH  per-slot allocation request.
REQ-006 alloc_rdy_o  output  ENQ_WIDTH  per-slot ready; a free entry is available for that slot.
REQ-007 alloc_tag_o  output  ENQ_WIDTH x ENTRY_TAG  tag offered to each slot, valid when alloc_rdy_o is high.
REQ-008 enq_vld_o  output  ENQ_WIDTH  enqueue strobe to the age-order selector (= alloc_vld_i & alloc_rdy_o).
REQ-009 enq_tag_o  output  ENQ_WIDTH x ENTRY_TAG  enqueue tag to the selector (= alloc_tag_o).
REQ-010 rel_vld_i  input  DEQ_WIDTH  release request.
REQ-011 rel_tag_i  input  DEQ_WIDTH x ENTRY_TAG  entry being released.
REQ-012 deq_vld_o  output  DEQ_WIDTH  dequeue strobe to the selector.
REQ-013 deq_tag_o  output  DEQ_WIDTH x ENTRY_TAG  dequeue tag to the selector.
REQ-014 flush_i  input  1  free all entries.
REQ-015 free_cnt_o  output  $clog2(ENTRY_COUNT+1)  registered count of free entries.
REQ-016 full_o / empty_o  output  1 each  no free entry / all entries free, both decoded from free_cnt_o.
REQ-017 err_o  output  1  sticky protocol-error flag.

Function
REQ-018 State SHALL be a registered free mask free_r[ENTRY_COUNT] (bit=1 means free), the count free_cnt_r, and err_r.
REQ-019 alloc_tag_o[i] SHALL be the index of the (i+1)-th lowest set bit of free_r; slot 0 takes the lowest free index.
REQ-020 alloc_rdy_o[i] SHALL be (free_cnt_r > i) & ~flush_i, independent of alloc_vld_i.
REQ-021 Each granted slot (enq_vld_o[i]=1) SHALL clear the free_r bit of its tag at the next edge; grants are zero-latency, with tag and strobe in the same cycle as the request.
REQ-022 Gaps in alloc_vld_i SHALL be legal; a non-requesting slot consumes no entry, but tag offsets still follow REQ-019.
REQ-023 deq_vld_o/deq_tag_o SHALL be rel_vld_i/rel_tag_i gated by ~flush_i, combinational and same cycle.
REQ-024 Each accepted release SHALL set the free_r bit of its tag at the next edge; a released entry is not offered for allocation in the release cycle.
REQ-025 Allocation and release in the same cycle SHALL both take effect; free_cnt_r(next) = free_cnt_r + accepted releases - grants.
REQ-026 Releasing an already-free entry, or two release ports naming the same tag in one cycle, SHALL set err_r; the free mask is OR-updated (no double count: the count is recomputed as the popcount of the next mask).
REQ-027 flush_i=1 SHALL suppress all grants and releases that cycle, set free_r to all-ones, set free_cnt_r to ENTRY_COUNT next cycle, and leave err_r unchanged.
REQ-028 full_o SHALL equal (free_cnt_r==0), and empty_o SHALL equal (free_cnt_r==ENTRY_COUNT).
REQ-029 err_r SHALL clear only on rst.

Reset
REQ-030 On rst: free_r = all-ones, free_cnt_r = ENTRY_COUNT, err_r = 0; therefore alloc_rdy_o = all-ones (ENQ_WIDTH<=ENTRY_COUNT), full_o=0, empty_o=1, err_o=0.
REQ-031 rst SHALL take priority over flush_i, alloc_vld_i and rel_vld_i in the same cycle; mid-operation reset discards all allocations.

Verification
REQ-032 Reset, then alloc_vld_i=1 for 4 cycles (ENTRY_COUNT=4, ENQ_WIDTH=1) -> enq_tag_o sequence 0,1,2,3; free_cnt_o 4,3,2,1 then 0; full_o=1; alloc_rdy_o=0 in cycle 5.
REQ-033 Full queue; release tag 2 and request allocation in the same cycle -> no grant that cycle; next cycle alloc_tag_o=2, alloc_rdy_o=1, free_cnt_o=1.
REQ-034 ENQ_WIDTH=2, free={1,3}, alloc_vld_i=2'b11 -> enq_tag_o={3,1} (slot1=3, slot0=1); next free_cnt_o=0; with alloc_vld_i=2'b10 -> only slot1 granted, with tag 3.
REQ-035 free_cnt_o=2 with allocation and release both active, then flush_i=1 -> enq_vld_o=0, deq_vld_o=0 that cycle; next cycle free_cnt_o=4, empty_o=1.
REQ-036 Release of free tag 0 -> err_o=1 next cycle and held across a flush; free_cnt_o unchanged; rst -> err_o=0.
REQ-037 Random allocation/release traffic, checked against a reference model: no tag is granted twice without an intervening release, and free_cnt_o always equals popcount(free_r).
